// File: rtl/cache_pkg.sv
// Shared address-field layout for the direct-mapped data cache.
// Byte offset [1:0], word in line [3:2], line index starting at bit 4, tag above.
package cache_pkg;

  localparam int WORD_OFFSET = 2;
  localparam int LINE_OFFSET = 4;
  localparam int WORD_SEL_W  = LINE_OFFSET - WORD_OFFSET;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;

  function automatic int tag_width(input int line_ix_bits);
    return ADDR_W - line_ix_bits - LINE_OFFSET;
  endfunction

endpackage

// File: rtl/cache_bram.sv
// Single-port synchronous RAM with a write-first, resettable read register.
// The storage array is named data so it can be preloaded hierarchically.
module cache_bram #(
  parameter int DATA_BITWIDTH    = 32,
  parameter int ADDRESS_BITWIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic                        we,
  input  logic [DATA_BITWIDTH-1:0]    din,
  output logic [DATA_BITWIDTH-1:0]    q
);

  logic [DATA_BITWIDTH-1:0] data [0:(1 << ADDRESS_BITWIDTH)-1];

  // Array has no reset; a write while rst_n is low is dropped.
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      data[addr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= din;
    end else begin
      q <= data[addr];
    end
  end

endmodule

// File: rtl/cache.sv
// Direct-mapped cache array: one tag RAM ({valid, tag}) and four word RAMs per line.
// One-cycle read latency; hit is resolved on the registered tag and address tag.
module cache
  import cache_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  input  logic [31:0] data_in,
  input  logic        write_enable
);

  localparam int TAG_W = tag_width(LINE_IX_BITWIDTH);

  logic [LINE_IX_BITWIDTH-1:0] line_ix;
  logic [WORD_SEL_W-1:0]       word_sel;
  logic [TAG_W-1:0]            addr_tag;
  logic                        unused_byte_bits;

  assign line_ix          = address[LINE_OFFSET +: LINE_IX_BITWIDTH];
  assign word_sel         = address[WORD_OFFSET +: WORD_SEL_W];
  assign addr_tag         = address[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^address[WORD_OFFSET-1:0];

  logic [TAG_W:0]  tag_q;
  logic [DATA_W-1:0] word_q [4];
  logic [3:0]      word_we;

  always_comb begin
    word_we = '0;
    word_we[word_sel] = write_enable;
  end

  cache_bram #(.DATA_BITWIDTH(TAG_W + 1), .ADDRESS_BITWIDTH(LINE_IX_BITWIDTH)) tag (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (line_ix),
    .we   (write_enable),
    .din  ({1'b1, addr_tag}),
    .q    (tag_q)
  );

  cache_bram #(.DATA_BITWIDTH(DATA_W), .ADDRESS_BITWIDTH(LINE_IX_BITWIDTH)) data0 (
    .clk(clk), .rst_n(rst_n), .addr(line_ix), .we(word_we[0]), .din(data_in), .q(word_q[0])
  );
  cache_bram #(.DATA_BITWIDTH(DATA_W), .ADDRESS_BITWIDTH(LINE_IX_BITWIDTH)) data1 (
    .clk(clk), .rst_n(rst_n), .addr(line_ix), .we(word_we[1]), .din(data_in), .q(word_q[1])
  );
  cache_bram #(.DATA_BITWIDTH(DATA_W), .ADDRESS_BITWIDTH(LINE_IX_BITWIDTH)) data2 (
    .clk(clk), .rst_n(rst_n), .addr(line_ix), .we(word_we[2]), .din(data_in), .q(word_q[2])
  );
  cache_bram #(.DATA_BITWIDTH(DATA_W), .ADDRESS_BITWIDTH(LINE_IX_BITWIDTH)) data3 (
    .clk(clk), .rst_n(rst_n), .addr(line_ix), .we(word_we[3]), .din(data_in), .q(word_q[3])
  );

  // Address fields aligned with the RAM read registers
  logic [WORD_SEL_W-1:0] word_sel_p1;
  logic [TAG_W-1:0]      addr_tag_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_sel_p1 <= '0;
      addr_tag_p1 <= '0;
    end else begin
      word_sel_p1 <= word_sel;
      addr_tag_p1 <= addr_tag;
    end
  end

  assign data_out       = word_q[word_sel_p1];
  assign data_out_valid = tag_q[TAG_W] && (tag_q[TAG_W-1:0] == addr_tag_p1);

endmodule

// File: tb/tb_cache.sv
// Directed bench for the direct-mapped cache array with hand-computed expectations.
module tb_cache;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        data_out_valid;
  logic [31:0] data_in;
  logic        write_enable;

  int total = 0;
  int bad   = 0;

  cache #(.LINE_IX_BITWIDTH(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .address       (address),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_in       (data_in),
    .write_enable  (write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", name, obs, exp);
    end
  endtask

  // Present one access, let one rising edge take it, return 1 time unit after that edge.
  task automatic step(input logic [31:0] a, input logic we, input logic [31:0] d);
    address      = a;
    write_enable = we;
    data_in      = d;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    address      = '0;
    data_in      = '0;
    write_enable = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      dut.tag.data[i]   = '0;
      dut.data0.data[i] = '0;
      dut.data1.data[i] = '0;
      dut.data2.data[i] = '0;
      dut.data3.data[i] = '0;
    end
    @(posedge clk);
    #1;
    check("reset_data", data_out, 32'h0);
    check("reset_valid", {31'b0, data_out_valid}, 32'h0);
    rst_n = 1'b1;

    // Write-first: each write is visible right after its edge
    step(32'h4, 1'b1, 32'habcd_ef12);
    check("wr4_data", data_out, 32'habcd_ef12);
    check("wr4_valid", {31'b0, data_out_valid}, 32'h1);
    step(32'h8, 1'b1, 32'habcd_1234);
    check("wr8_data", data_out, 32'habcd_1234);
    check("wr8_valid", {31'b0, data_out_valid}, 32'h1);

    step(32'h4, 1'b0, 32'h0);
    check("rd4_data", data_out, 32'habcd_ef12);
    check("rd4_valid", {31'b0, data_out_valid}, 32'h1);
    step(32'h8, 1'b0, 32'h0);
    check("rd8_data", data_out, 32'habcd_1234);
    check("rd8_valid", {31'b0, data_out_valid}, 32'h1);

    // Line 1 was never written: zeroed valid bit means miss
    step(32'h10, 1'b0, 32'h0);
    check("rd16_valid", {31'b0, data_out_valid}, 32'h0);

    // 0x1_0004 aliases line 0 word 1 with tag 4
    step(32'h1_0004, 1'b1, 32'h1111_2222);
    check("wr_alias_data", data_out, 32'h1111_2222);
    check("wr_alias_valid", {31'b0, data_out_valid}, 32'h1);
    step(32'h4, 1'b0, 32'h0);
    check("rd4_after_alias_valid", {31'b0, data_out_valid}, 32'h0);
    step(32'h8, 1'b0, 32'h0);
    check("rd8_after_alias_valid", {31'b0, data_out_valid}, 32'h0);
    step(32'h1_0004, 1'b0, 32'h0);
    check("rd_alias_data", data_out, 32'h1111_2222);
    check("rd_alias_valid", {31'b0, data_out_valid}, 32'h1);

    // Restore tag 0 on line 0; word 2 (abcd_1234) was never overwritten
    step(32'h4, 1'b1, 32'habcd_ef12);
    step(32'h8, 1'b0, 32'h0);
    check("rd8_restored_data", data_out, 32'habcd_1234);
    check("rd8_restored_valid", {31'b0, data_out_valid}, 32'h1);

    // Asynchronous reset between edges clears outputs at once
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", data_out, 32'h0);
    check("async_rst_valid", {31'b0, data_out_valid}, 32'h0);
    // A write on an edge with rst_n low must be dropped
    step(32'h8, 1'b1, 32'hdead_beef);
    check("rst_hold_data", data_out, 32'h0);
    rst_n = 1'b1;
    step(32'h8, 1'b0, 32'h0);
    check("post_rst_rd8_data", data_out, 32'habcd_1234);
    check("post_rst_rd8_valid", {31'b0, data_out_valid}, 32'h1);

    // Last line, all four words back to back
    step(32'h3FF0, 1'b1, 32'h0000_1023);
    step(32'h3FF4, 1'b1, 32'h1111_1023);
    step(32'h3FF8, 1'b1, 32'h2222_1023);
    step(32'h3FFC, 1'b1, 32'h3333_1023);
    check("wr3ffc_data", data_out, 32'h3333_1023);
    step(32'h3FF0, 1'b0, 32'h0);
    check("rd3ff0_data", data_out, 32'h0000_1023);
    check("rd3ff0_valid", {31'b0, data_out_valid}, 32'h1);
    step(32'h3FF4, 1'b0, 32'h0);
    check("rd3ff4_data", data_out, 32'h1111_1023);
    check("rd3ff4_valid", {31'b0, data_out_valid}, 32'h1);
    step(32'h3FF8, 1'b0, 32'h0);
    check("rd3ff8_data", data_out, 32'h2222_1023);
    check("rd3ff8_valid", {31'b0, data_out_valid}, 32'h1);
    step(32'h3FFC, 1'b0, 32'h0);
    check("rd3ffc_data", data_out, 32'h3333_1023);
    check("rd3ffc_valid", {31'b0, data_out_valid}, 32'h1);

    // Line 0 words stay intact after activity elsewhere
    step(32'h4, 1'b0, 32'h0);
    check("final_rd4_data", data_out, 32'habcd_ef12);
    check("final_rd4_valid", {31'b0, data_out_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
